io_port_arbiter: RTL
====================

Name: io_port_arbiter

Overview:
- Shares the single memory-mapped IO port (UART status/data window at 32'h8000_0000-32'h8000_000F) between two requesters: requester 0 is the core data port, requester 1 is the debug/loader port.
- Round-robin arbitration, one transaction per cycle. Read data is returned one cycle after grant, matching the IO block's registered read.
- Optional lock lets a requester run an atomic sequence, e.g. poll output_bytes_avai and then write output_bytes, without interleaving.
- A lock watchdog prevents a stalled owner from starving the other requester.

Parameters:
- WORD_WIDTH_IN_BIT, 32, data width of all data buses.
- LOCK_TIMEOUT, 64, idle cycles a lock owner may stay silent before the lock is force-released; must be >= 2.
- TIMEOUT_CNT_WIDTH, 7, counter width; must satisfy 2^TIMEOUT_CNT_WIDTH > LOCK_TIMEOUT.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- r0_req  in  1  requester 0 transaction request; held until granted
- r0_lock  in  1  request to keep ownership after this transaction
- r0_we  in  4  byte write enables; 0 = read
- r0_addr  in  32  byte address
- r0_wdata  in  WORD_WIDTH_IN_BIT  write data
- r0_gnt  out  1  transaction accepted this cycle (combinational)
- r0_rvalid  out  1  response for the transaction granted last cycle
- r0_rdata  out  WORD_WIDTH_IN_BIT  read data, valid with r0_rvalid
- r1_req, r1_lock, r1_we, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata  same as r0_*, for requester 1
- io_en  out  1  to IO port en_a
- io_we  out  4  to IO port we_a
- io_addr  out  32  to IO port addr_a
- io_din  out  WORD_WIDTH_IN_BIT  to IO port din_a
- io_dout  in  WORD_WIDTH_IN_BIT  from IO port dout_a, registered by the IO block
- lock_owner  out  2  bit i set = requester i holds the lock (debug visibility)
- lock_expired  out  1  one-cycle pulse when the watchdog force-releases a lock

Behaviour:
- Reset is active-low and synchronous on clk; reset (low) takes priority over all other activity.
- Values while reset is low:
  - state = UNLOCKED, prio pointer = 0, lock_owner = 0, lock_expired = 0, timeout counter = 0, r*_rvalid = 0.
  - gnt outputs forced to 0 and io_en forced to 0 combinationally while reset is low.
- States: UNLOCKED, LOCKED0, LOCKED1.
- UNLOCKED arbitration:
  - Grant the sole requester.
  - If both request, grant the requester selected by prio.
  - After any grant, prio points to the other requester.
- LOCKEDn: only requester n may be granted; the other requester's req is ignored (held, no gnt).
- Lock transitions:
  - A grant with rN_lock=1 enters or stays in LOCKEDn.
  - A grant by owner n with lock=0 returns to UNLOCKED at the next edge; that transaction itself completes normally.
- Datapath:
  - io_en = |gnt; io_we/io_addr/io_din are muxed combinationally from the granted requester.
  - When nothing is granted, io_we = 0 and io_addr/io_din are don't-care.
- Response:
  - Registered resp_owner, captured on grant.
  - rN_rvalid pulses exactly 1 cycle after rN_gnt, for both reads and writes.
  - rN_rdata = io_dout when the corresponding rvalid is high; otherwise 0.
  - Latency is fixed at 1 cycle. Back-to-back grants to the same requester give back-to-back rvalid.
- Watchdog:
  - In LOCKEDn the counter increments on each cycle without rN_req and clears on rN_req.
  - When the counter reaches LOCKEDn timeout (count == LOCK_TIMEOUT-1 with no req): go to UNLOCKED, set prio to the other requester, pulse lock_expired for 1 cycle, clear the counter.
- Boundary conditions:
  - Simultaneous lock requests from both in UNLOCKED: prio winner locks; the loser waits.
  - Owner requesting on the expiry cycle: the request is granted and the counter clears, so no expiry occurs.
  - Reset asserted with a transaction in flight: the pending rvalid is suppressed (no response is delivered).
  - Addresses are not decoded; out-of-window accesses pass through unchanged.

Decomposition:
- Shared package io_arb_pkg holds: state encoding (UNLOCKED=2'd0, LOCKED0=2'd1, LOCKED1=2'd2) and the IO window address constants (32'h8000_0000/04/08/0C) used by benches.
- One sub-module: rr_arbiter2, a pure 2-way round-robin grant given req, prio and mask. The lock FSM and watchdog stay at top level.

Test Plan:
- Single read: r0 read of 32'h8000_0000 with io_dout=32 -> r0_gnt in cycle 0; r0_rvalid and r0_rdata=32 in cycle 1; r1 sees no response.
- Contention, no lock: both requesters request continuously for 4 cycles from reset -> grant order r0, r1, r0, r1; each rvalid follows its gnt by 1 cycle.
- Lock sequence: r1 reads 32'h8000_0000 with lock=1, then writes 32'h0000_0041 to 32'h8000_0004 with lock=0, while r0 requests throughout -> r0_gnt stays 0 for both cycles and is granted in cycle 2; io_we=4'hF only on the write cycle.
- Watchdog: r0 locks, then idles while r1 requests; LOCK_TIMEOUT=64 -> lock_expired pulses 64 cycles after the last r0 grant; r1_gnt follows on the next cycle.
- Reset mid-transaction: r0 read granted, reset driven low in the following cycle -> r0_rvalid=0, lock_owner=0, io_en=0; after release, r1-only request is granted immediately.
- Write ack: r1 write with we=4'b0001 -> r1_rvalid pulses 1 cycle later; io_din=r1_wdata on the grant cycle.

Source files
------------

// File: rtl/io_arb_pkg.sv
// Shared definitions for the IO port arbiter: lock FSM encoding and the
// UART status/data window addresses.
package io_arb_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED0  = 2'd1,
        LOCKED1  = 2'd2
    } arb_state_t;

    localparam logic [31:0] IO_WIN_ADDR0 = 32'h8000_0000;
    localparam logic [31:0] IO_WIN_ADDR1 = 32'h8000_0004;
    localparam logic [31:0] IO_WIN_ADDR2 = 32'h8000_0008;
    localparam logic [31:0] IO_WIN_ADDR3 = 32'h8000_000C;

endpackage

// File: rtl/rr_arbiter2.sv
// Pure 2-way round-robin grant: requests outside the mask are ignored, and a
// tie between eligible requesters goes to the one selected by prio.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       prio,
    input  logic [1:0] mask,
    output logic [1:0] gnt
);

    logic [1:0] eligible;

    assign eligible = req & mask;

    always_comb begin
        gnt = eligible;
        if (&eligible) begin
            gnt = prio ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/io_port_arbiter.sv
// Shares the single memory-mapped IO port between the core data port (r0) and
// the debug/loader port (r1), with optional locking and a lock watchdog.
module io_port_arbiter
    import io_arb_pkg::*;
#(
    parameter int WORD_WIDTH_IN_BIT = 32,
    parameter int LOCK_TIMEOUT      = 64,
    parameter int TIMEOUT_CNT_WIDTH = 7
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         r0_req,
    input  logic                         r0_lock,
    input  logic [3:0]                   r0_we,
    input  logic [31:0]                  r0_addr,
    input  logic [WORD_WIDTH_IN_BIT-1:0] r0_wdata,
    output logic                         r0_gnt,
    output logic                         r0_rvalid,
    output logic [WORD_WIDTH_IN_BIT-1:0] r0_rdata,
    input  logic                         r1_req,
    input  logic                         r1_lock,
    input  logic [3:0]                   r1_we,
    input  logic [31:0]                  r1_addr,
    input  logic [WORD_WIDTH_IN_BIT-1:0] r1_wdata,
    output logic                         r1_gnt,
    output logic                         r1_rvalid,
    output logic [WORD_WIDTH_IN_BIT-1:0] r1_rdata,
    output logic                         io_en,
    output logic [3:0]                   io_we,
    output logic [31:0]                  io_addr,
    output logic [WORD_WIDTH_IN_BIT-1:0] io_din,
    input  logic [WORD_WIDTH_IN_BIT-1:0] io_dout,
    output logic [1:0]                   lock_owner,
    output logic                         lock_expired
);

    localparam logic [TIMEOUT_CNT_WIDTH-1:0] CNT_LIMIT = TIMEOUT_CNT_WIDTH'(LOCK_TIMEOUT - 1);

    arb_state_t                   state_reg, state_next;
    logic                         prio_reg, prio_next;
    logic [TIMEOUT_CNT_WIDTH-1:0] count_reg, count_next;
    logic [1:0]                   resp_owner_reg;

    logic [1:0] req, lock, mask, arb_gnt, gnt, owner_onehot, rvalid;
    logic       owner_req, owner_lock, owner_idx, expire;
    logic [WORD_WIDTH_IN_BIT-1:0] rdata [2];

    assign req  = {r1_req, r0_req};
    assign lock = {r1_lock, r0_lock};

    rr_arbiter2 u_rr_arbiter2 (
        .req  (req),
        .prio (prio_reg),
        .mask (mask),
        .gnt  (arb_gnt)
    );

    // Grants are suppressed combinationally so nothing reaches the IO port in reset.
    assign gnt    = reset ? arb_gnt : 2'b00;
    assign r0_gnt = gnt[0];
    assign r1_gnt = gnt[1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= UNLOCKED;
            prio_reg       <= 1'b0;
            count_reg      <= '0;
            resp_owner_reg <= 2'b00;
        end else begin
            state_reg      <= state_next;
            prio_reg       <= prio_next;
            count_reg      <= count_next;
            resp_owner_reg <= gnt;
        end
    end

    always_comb begin
        state_next = state_reg;
        prio_next  = prio_reg;
        count_next = count_reg;
        if (|gnt) begin
            prio_next = ~gnt[1];
        end
        case (state_reg)
            LOCKED0, LOCKED1: begin
                if (owner_req) begin
                    count_next = '0;
                    if (!owner_lock) begin
                        state_next = UNLOCKED;
                    end
                end else if (expire) begin
                    state_next = UNLOCKED;
                    prio_next  = ~owner_idx;
                    count_next = '0;
                end else begin
                    count_next = count_reg + 1'b1;
                end
            end
            default: begin
                state_next = UNLOCKED;
                count_next = '0;
                if (gnt[0] && lock[0]) begin
                    state_next = LOCKED0;
                end else if (gnt[1] && lock[1]) begin
                    state_next = LOCKED1;
                end
            end
        endcase
    end

    always_comb begin
        mask         = 2'b11;
        owner_onehot = 2'b00;
        case (state_reg)
            LOCKED0: begin
                mask         = 2'b01;
                owner_onehot = 2'b01;
            end
            LOCKED1: begin
                mask         = 2'b10;
                owner_onehot = 2'b10;
            end
            default: ;
        endcase
    end

    assign owner_idx    = owner_onehot[1];
    assign owner_req    = |(req & owner_onehot);
    assign owner_lock   = |(lock & owner_onehot);
    assign expire       = (|owner_onehot) && !owner_req && (count_reg == CNT_LIMIT);
    assign lock_expired = reset && expire;
    assign lock_owner   = reset ? owner_onehot : 2'b00;

    assign io_en   = |gnt;
    assign io_we   = gnt[1] ? r1_we : (gnt[0] ? r0_we : 4'h0);
    assign io_addr = gnt[1] ? r1_addr : r0_addr;
    assign io_din  = gnt[1] ? r1_wdata : r0_wdata;

    // A response still in flight when reset drops is discarded, not delivered.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_resp
            assign rvalid[gi] = reset & resp_owner_reg[gi];
            assign rdata[gi]  = rvalid[gi] ? io_dout : '0;
        end
    endgenerate

    assign r0_rvalid = rvalid[0];
    assign r1_rvalid = rvalid[1];
    assign r0_rdata  = rdata[0];
    assign r1_rdata  = rdata[1];

endmodule
